// File: rtl/gg_emulation_insert.sv
// gg_emulation_insert
// Transmit-side emulation prevention: expands a big-endian RBSP byte stream
// (128-bit words) by inserting 0x03 after any 00 00 pair that is followed by
// a byte <= 0x03, and after a NAL that ends in 00 00. Expanded bytes collect in
// a 48-byte FIFO and leave as 128-bit words with a byte count on the last word.
//
// Handshake: a word moves on a port only in a cycle where valid && ready are
// both high at the rising clock edge. A producer holding valid keeps its data
// stable until the transfer. Here oport/olast/olen stay stable while
// oport_valid=1 and oport_ready=0. iport_ready does not depend on iport_valid.
module gg_emulation_insert #(
  parameter int WIDTH      = 128,
  parameter int BYTE_WIDTH = WIDTH / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] iport,
  input  logic             iport_valid,
  output logic             iport_ready,
  input  logic             ilast,
  input  logic [4:0]       ilen,
  output logic [WIDTH-1:0] oport,
  output logic             oport_valid,
  input  logic             oport_ready,
  output logic             olast,
  output logic [4:0]       olen
);

  localparam int BUF_BYTES = 48;
  // Worst case for one word is 25 bytes; 32 entries keep the 5-bit index in range.
  localparam int EXP_BYTES = 32;

  // Byte FIFO. Byte 0 is the head, i.e. the next byte to leave on oport.
  // Entries at or beyond fill are always zero.
  logic [7:0] buf_q    [BUF_BYTES];
  logic [7:0] buf_next [BUF_BYTES];
  logic [5:0] fill;
  logic [5:0] fill_next;

  // Count of trailing 0x00 bytes already emitted, saturating at 2.
  logic [1:0] zc;
  // High from ilast acceptance until the olast word has been consumed.
  logic       drain;

  // Expansion results for the word presented on iport.
  logic [7:0] exp_byte [EXP_BYTES];
  logic [4:0] exp_cnt;
  logic [1:0] exp_zc;
  logic [7:0] cur_b;
  logic [1:0] zc_v;

  logic       in_fire;
  logic       out_fire;
  logic [5:0] pop_n;
  logic [5:0] push_n;
  logic [5:0] base;

  // Ready/valid and output framing, all derived from registered state.
  // Accepting only at fill <= 23 leaves room for a 25-byte worst-case word.
  assign iport_ready = !drain && (fill <= 6'd23);
  assign oport_valid = (fill >= 6'd16) || (drain && (fill != 6'd0));
  assign olast       = oport_valid && drain && (fill <= 6'd16);
  assign olen        = !oport_valid ? 5'd0 : (olast ? fill[4:0] : 5'd16);

  assign in_fire  = iport_valid && iport_ready;
  assign out_fire = oport_valid && oport_ready;
  assign pop_n    = out_fire ? {1'b0, olen} : 6'd0;
  assign push_n   = in_fire ? {1'b0, exp_cnt} : 6'd0;
  assign base     = fill - pop_n;
  assign fill_next = base + push_n;

  // Present the head bytes, masking positions at or beyond olen to 0x00.
  always_comb begin
    oport = '0;
    for (int j = 0; j < BYTE_WIDTH; j++) begin
      if (5'(j) < olen) begin
        oport[WIDTH-1-8*j -: 8] = buf_q[j];
      end
    end
  end

  // 16-stage insertion chain over the input word, plus the trailing 0x03
  // that closes a NAL ending in 00 00.
  always_comb begin
    for (int k = 0; k < EXP_BYTES; k++) begin
      exp_byte[k] = 8'h00;
    end
    exp_cnt = 5'd0;
    zc_v    = zc;
    cur_b   = 8'h00;
    for (int i = 0; i < BYTE_WIDTH; i++) begin
      cur_b = iport[WIDTH-1-8*i -: 8];
      if (!ilast || (5'(i) < ilen)) begin
        if ((zc_v == 2'd2) && (cur_b <= 8'h03)) begin
          exp_byte[exp_cnt] = 8'h03;
          exp_cnt           = exp_cnt + 5'd1;
          zc_v              = 2'd0;
        end
        exp_byte[exp_cnt] = cur_b;
        exp_cnt           = exp_cnt + 5'd1;
        if (cur_b == 8'h00) begin
          zc_v = (zc_v == 2'd2) ? 2'd2 : zc_v + 2'd1;
        end else begin
          zc_v = 2'd0;
        end
      end
    end
    if (ilast && (zc_v == 2'd2)) begin
      exp_byte[exp_cnt] = 8'h03;
      exp_cnt           = exp_cnt + 5'd1;
      zc_v              = 2'd0;
    end
    // Each NAL starts with a clean zero run.
    exp_zc = ilast ? 2'd0 : zc_v;
  end

  // Next FIFO image: survivors of the pop shift to the head, then the
  // expanded bytes land right behind them.
  always_comb begin
    for (int j = 0; j < BUF_BYTES; j++) begin
      buf_next[j] = 8'h00;
      if (6'(j) < base) begin
        buf_next[j] = buf_q[6'(j) + pop_n];
      end else if (6'(j) < fill_next) begin
        buf_next[j] = exp_byte[5'(6'(j) - base)];
      end
    end
  end

  // State registers: FIFO contents, fill level, zero run and drain flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < BUF_BYTES; j++) begin
        buf_q[j] <= 8'h00;
      end
      fill  <= 6'd0;
      zc    <= 2'd0;
      drain <= 1'b0;
    end else begin
      buf_q <= buf_next;
      fill  <= fill_next;
      if (in_fire) begin
        zc <= exp_zc;
      end
      if (in_fire && ilast) begin
        drain <= 1'b1;
      end else if (out_fire && olast) begin
        drain <= 1'b0;
      end
    end
  end

  a_fill_max: assert property (@(posedge clk) disable iff (reset) fill <= 6'd48);
  a_olen_fill: assert property (@(posedge clk) disable iff (reset) {1'b0, olen} <= fill);

endmodule

// File: tb/tb_gg_emulation_insert.sv
// Bench for gg_emulation_insert: byte-level reference model feeding an
// expected-word queue, a monitor popping it on each output handshake, and
// directed sequences for insertion, drain, throttling, stall and reset.
module tb_gg_emulation_insert;

  localparam int W = 134;  // {data[127:0], len[4:0], last}

  logic         clk;
  logic         reset;
  logic [127:0] iport;
  logic         iport_valid;
  logic         iport_ready;
  logic         ilast;
  logic [4:0]   ilen;
  logic [127:0] oport;
  logic         oport_valid;
  logic         oport_ready;
  logic         olast;
  logic [4:0]   olen;

  gg_emulation_insert dut (
    .clk         (clk),
    .reset       (reset),
    .iport       (iport),
    .iport_valid (iport_valid),
    .iport_ready (iport_ready),
    .ilast       (ilast),
    .ilen        (ilen),
    .oport       (oport),
    .oport_valid (oport_valid),
    .oport_ready (oport_ready),
    .olast       (olast),
    .olen        (olen)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int             n_checks = 0;
  int             n_errors = 0;
  logic [W-1:0]   exp_q[$];
  logic [7:0]     mq[$];
  logic [1:0]     mzc = 2'd0;
  logic [127:0]   out_log[$];
  logic [4:0]     len_log[$];
  logic           last_log[$];
  logic [W-1:0]   mon_e;
  int             max_fill = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_emit(input int n, input logic last);
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < n; i++) d[127-8*i -: 8] = mq.pop_front();
    exp_q.push_back({d, 5'(n), last});
  endtask

  // Reference: byte-serial insertion rule, then cut into 16-byte words.
  task automatic model_accept(input logic [127:0] data, input logic last, input logic [4:0] len);
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      if (!last || i < int'(len)) begin
        b = data[127-8*i -: 8];
        if (mzc == 2'd2 && b <= 8'h03) begin
          mq.push_back(8'h03);
          mzc = 2'd0;
        end
        mq.push_back(b);
        mzc = (b == 8'h00) ? ((mzc == 2'd2) ? 2'd2 : mzc + 2'd1) : 2'd0;
      end
    end
    if (last) begin
      if (mzc == 2'd2) mq.push_back(8'h03);
      mzc = 2'd0;
      while (mq.size() > 16) model_emit(16, 1'b0);
      model_emit(mq.size(), 1'b1);
    end else begin
      while (mq.size() >= 16) model_emit(16, 1'b0);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (int'(dut.fill) > max_fill) max_fill = int'(dut.fill);
      if (oport_valid && oport_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", oport, 128'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("odata", oport, mon_e[133:6]);
          check_eq("olen", 128'(olen), 128'(mon_e[5:1]));
          check_eq("olast", 128'(olast), 128'(mon_e[0]));
        end
        out_log.push_back(oport);
        len_log.push_back(olen);
        last_log.push_back(olast);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [127:0] data, input logic last, input logic [4:0] len,
                           output int waits);
    bit accepted;
    accepted    = 1'b0;
    waits       = 0;
    iport       = data;
    ilast       = last;
    ilen        = len;
    iport_valid = 1'b1;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge clk);
      if (iport_ready) begin
        model_accept(data, last, len);
        accepted = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    iport_valid = 1'b0;
    if (!accepted) check_eq("accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !oport_valid && iport_ready) done = 1'b1;
    end
    check_eq("drain_done", 128'(done), 128'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_nz_word();
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[127-8*i -: 8] = 8'($urandom_range(16, 254));
    return d;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int           waits;
    int           total_waits;
    int           base_n;
    int           acc;
    bit           have_snap;
    logic [127:0] snap_data;
    logic [4:0]   snap_len;
    logic         snap_last;
    logic [127:0] w;

    reset       = 1'b1;
    iport       = '0;
    iport_valid = 1'b0;
    ilast       = 1'b0;
    ilen        = 5'd0;
    oport_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_iport_ready", 128'(iport_ready), 128'd1);
    check_eq("rst_oport_valid", 128'(oport_valid), 128'd0);
    check_eq("rst_olast", 128'(olast), 128'd0);
    check_eq("rst_olen", 128'(olen), 128'd0);
    check_eq("rst_oport", oport, 128'd0);
    check_eq("rst_fill", 128'(dut.fill), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // No zeros: pass-through, one word per cycle, 1-cycle latency.
    base_n = out_log.size();
    w = 128'h1112131415161718191A1B1C1D1E1F20;
    send_word(w, 1'b0, 5'd16, waits);
    check_eq("first_valid_latency", 128'(oport_valid), 128'd1);
    check_eq("t1_ready0", 128'(waits), 128'd0);
    for (int k = 1; k < 4; k++) begin
      send_word(w, (k == 3), 5'd16, waits);
      check_eq("t1_ready", 128'(waits), 128'd0);
    end
    wait_drain();
    check_eq("t1_words", 128'(out_log.size() - base_n), 128'd4);
    check_eq("t1_data", out_log[base_n + 2], w);

    // One insertion inside the word, one overflow byte.
    base_n = out_log.size();
    send_word(128'h000001000004AAAAAAAAAAAAAAAAAAAA, 1'b0, 5'd16, waits);
    send_word({8'h55, 120'h0}, 1'b1, 5'd1, waits);
    wait_drain();
    check_eq("t2_first", out_log[base_n], 128'h00000301000004AAAAAAAAAAAAAAAAAA);
    check_eq("t2_tail", out_log[base_n + 1], {16'hAA55, 112'h0});
    check_eq("t2_tail_len", 128'(len_log[base_n + 1]), 128'd2);

    // Zero run crosses the word boundary; 00 00 03 input gains a 03.
    base_n = out_log.size();
    send_word(128'h11111111111111111111111111110000, 1'b0, 5'd16, waits);
    send_word(128'h02000003222222222222222222222222, 1'b1, 5'd16, waits);
    wait_drain();
    check_eq("t3_a", out_log[base_n], 128'h11111111111111111111111111110000);
    check_eq("t3_b", out_log[base_n + 1], 128'h03020000030322222222222222222222);
    check_eq("t3_last", 128'(last_log[base_n + 2]), 128'd1);

    // Continuous zeros: 00 00 03 pattern, throttled to 2 in per 3 out.
    base_n      = out_log.size();
    max_fill    = 0;
    total_waits = 0;
    for (int k = 0; k < 7; k++) begin
      send_word(128'h0, (k == 6), 5'd16, waits);
      total_waits += waits;
    end
    wait_drain();
    check_eq("t4_throttle_waits", 128'(total_waits), 128'd5);
    check_eq("t4_words", 128'(out_log.size() - base_n), 128'd11);
    check_eq("t4_pattern", out_log[base_n + 1], 128'h00030000030000030000030000030000);
    check_eq("t4_max_fill_le48", 128'(max_fill <= 48), 128'd1);

    // Short NAL with trailing insertion, then zc must be clear for the next NAL.
    base_n = out_log.size();
    send_word(128'hAABBCC00007777777777777777777777, 1'b1, 5'd5, waits);
    check_eq("t5_ready_drain", 128'(iport_ready), 128'd0);
    wait_drain();
    check_eq("t5_data", out_log[base_n], 128'hAABBCC00000300000000000000000000);
    check_eq("t5_len", 128'(len_log[base_n]), 128'd6);
    check_eq("t5_last", 128'(last_log[base_n]), 128'd1);
    send_word({8'h01, 120'h0}, 1'b1, 5'd1, waits);
    wait_drain();
    check_eq("t5_next_nal", out_log[base_n + 1], {8'h01, 120'h0});
    check_eq("t5_next_len", 128'(len_log[base_n + 1]), 128'd1);

    // Output stall for 10 cycles, then reset in the middle of it.
    oport_ready = 1'b0;
    acc         = 0;
    have_snap   = 1'b0;
    snap_data   = '0;
    snap_len    = '0;
    snap_last   = 1'b0;
    iport       = rand_nz_word();
    ilast       = 1'b0;
    ilen        = 5'd16;
    iport_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (oport_valid && !have_snap) begin
        have_snap = 1'b1;
        snap_data = oport;
        snap_len  = olen;
        snap_last = olast;
      end else if (have_snap) begin
        check_eq("stall_oport", oport, snap_data);
        check_eq("stall_olen", 128'(olen), 128'(snap_len));
        check_eq("stall_olast", 128'(olast), 128'(snap_last));
      end
      if (iport_ready) begin
        model_accept(iport, 1'b0, 5'd16);
        acc++;
      end
      @(posedge clk);
      #1;
      iport = rand_nz_word();
    end
    iport_valid = 1'b0;
    check_eq("stall_accepts", 128'(acc), 128'd2);
    #2;
    reset = 1'b1;
    #1;
    check_eq("reset_valid_now", 128'(oport_valid), 128'd0);
    exp_q.delete();
    mq.delete();
    mzc = 2'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("post_rst_fill", 128'(dut.fill), 128'd0);
    check_eq("post_rst_ready", 128'(iport_ready), 128'd1);
    oport_ready = 1'b1;
    @(posedge clk);
    #1;
    base_n = out_log.size();
    send_word({24'h5A5A5A, 104'h0}, 1'b1, 5'd3, waits);
    wait_drain();
    check_eq("post_rst_nal", out_log[base_n], {24'h5A5A5A, 104'h0});

    check_eq("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gg_emulation_insert.md
# gg_emulation_insert

Encoder-side emulation prevention inserter. It takes a big-endian RBSP byte stream in 128-bit AXI-S words and inserts 0x03 emulation prevention bytes wherever the H.264 rules require them. It emits the expanded NAL payload as 128-bit AXI-S words with a last-word byte count. It sits between the slice/header bitstream packer and the NAL/start-code framer, and is the transmit-side counterpart of `gg_emulation_remove`.

## Interface
- WIDTH, 128, datapath width in bits; only 128 is supported.
- BYTE_WIDTH, WIDTH/8, bytes per word.
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- iport  in  128  RBSP bytes, big endian; byte 0 is in iport[127:120].
- iport_valid  in  1  input word valid.
- iport_ready  out  1  input word accepted when iport_valid && iport_ready.
- ilast  in  1  current input word is the last word of the NAL.
- ilen  in  5  number of valid bytes when ilast=1 (1..16), counted from byte 0; ignored otherwise (word treated as 16 bytes).
- oport  out  128  expanded bytes, big endian; bytes at positions ≥ olen are 0x00.
- oport_valid  out  1  output word valid.
- oport_ready  in  1  output word consumed when oport_valid && oport_ready.
- olast  out  1  final word of the NAL.
- olen  out  5  valid bytes in the output word: 16 unless olast, in which case 1..16.

## Operation
- Insertion rule, applied per byte in stream order. zc is the count of consecutive 0x00 bytes in the *output* stream, saturating at 2.
  - For input byte b: if zc==2 and b≤0x03, emit 0x03 and set zc=0.
  - Then emit b. Set zc = (b==0x00) ? min(zc+1,2) : 0.
- Trailing rule: after the last valid byte of an ilast word, if zc==2, append one 0x03.
- zc carries across words. It clears to 0 after an ilast word is processed, because each NAL is independent.
- Expansion of one word is a 16-stage combinational chain. It produces 16..24 bytes, or 1..25 for an ilast word, and writes them to the tail of a 48-byte FIFO byte buffer. The buffer byte count `fill` ranges 0..48.
  - Worst case: all-zero input alternates 00 00 03, giving 24 bytes per 16.
- iport_ready = !drain && (fill ≤ 23). This guarantees fill ≤ 48 after any accept.
- drain is set on acceptance of an ilast word. It clears when the olast word is consumed.
- Output is driven from buffer bytes [0..15]:
  - oport_valid = (fill ≥ 16) || (drain && fill > 0).
  - olast = drain && (fill ≤ 16).
  - olen = olast ? fill : 16.
- On an output handshake, the buffer pops olen bytes and the remaining bytes shift to the head.
- A push and a pop in the same cycle are legal: fill_next = fill + pushed − popped.
- Output words never contain bytes from two different NALs, because input is blocked during drain.

## Timing
- Reset values: iport_ready=1, oport_valid=0, olast=0, olen=0, oport=0, fill=0, zc=0, drain=0.
- Reset asserted mid-NAL discards buffered bytes and state immediately (asynchronous). No olast is produced for the aborted NAL.
- Latency: bytes accepted in cycle N appear on oport in cycle N+1 at the earliest.
- Throughput: one input word per cycle while average expansion is ≤16 bytes per word and oport_ready=1. Expansion backlog throttles via iport_ready.
- While oport_valid=1 and oport_ready=0, oport, olast and olen are held stable. A push only appends at the tail and cannot change olast, because pushes are blocked during drain.
- After ilast is accepted, iport_ready stays 0 until the cycle after the olast handshake.
- fill never exceeds 48. An assertion checks fill ≤ 48 and olen ≤ fill.

## Test plan
- Four words of 0x11..0x20 patterns with no zeros, back to back, oport_ready=1:
  - Outputs are identical, one per cycle, first oport_valid 1 cycle after the first accept.
  - iport_ready stays 1 throughout.
- Word 00 00 01 00 00 04 AA…AA:
  - Output starts 00 00 03 01 00 00 04, with only one 0x03 inserted.
  - The 1 overflow byte leads the next output word.
- Cross-word case: word A ends …00 00, word B starts 02 …:
  - 0x03 is inserted at the head of word B's bytes.
  - Also check 00 00 03 input is emitted as 00 00 03 03.
- Continuous all-zero words:
  - Output is the repeating 00 00 03 pattern.
  - iport_ready deasserts to sustain exactly 2 input words per 3 output words.
  - fill never exceeds 48.
- Single NAL with ilast=1, ilen=5, bytes AA BB CC 00 00:
  - One output word AA BB CC 00 00 03, olen=6, olast=1, remaining bytes 0x00.
  - The next NAL's first byte 0x01 gets no insertion, confirming zc was cleared.
- oport_ready=0 for 10 cycles mid-stream:
  - oport, olast and olen are stable, and iport_ready drops once fill > 23.
  - Assert reset during the stall: oport_valid=0 in the same cycle, and fill=0 after reset releases.
